// File: rtl/cam_fb_writer_if.sv
// Camera byte stream in, frame buffer write port and status out.
// master: drives the camera stream. slave: the frame buffer writer.
interface cam_fb_writer_if #(
  parameter int ADDR_W = 17
);
  logic              pix_en;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_wAddr;
  logic [11:0]       fb_wdata;
  logic              frame_done;
  logic              frame_active;
  logic              overflow;

  modport master (
    output pix_en, cam_vsync, cam_href, cam_data,
    input  fb_we, fb_wAddr, fb_wdata, frame_done, frame_active, overflow
  );

  modport slave (
    input  pix_en, cam_vsync, cam_href, cam_data,
    output fb_we, fb_wAddr, fb_wdata, frame_done, frame_active, overflow
  );
endinterface

// File: rtl/cam_fb_writer.sv
// cam_fb_writer: RGB565 camera byte stream -> RGB444 frame buffer writes.
// Optional macro CAM_DECIMATE_EN: source is 2x the stored size in both axes;
// only even-column/even-line source pixels are stored.
module cam_fb_writer #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 240,
  parameter int ADDR_W  = 17
) (
  input logic             clk,
  input logic             reset,
  cam_fb_writer_if.slave  bus
);

`ifdef CAM_DECIMATE_EN
  localparam int COL_LIM  = 2 * H_PIX;
  localparam int LINE_LIM = 2 * V_LINES;
`else
  localparam int COL_LIM  = H_PIX;
  localparam int LINE_LIM = V_LINES;
`endif
  localparam int CW = $clog2(COL_LIM + 1);
  localparam int LW = $clog2(LINE_LIM + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COL_LIM);
  localparam logic [LW-1:0] LINE_MAX = LW'(LINE_LIM);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  state_t            state, nxt;
  logic [CW-1:0]     col_cnt;
  logic [LW-1:0]     line_cnt;
  logic              phase_lo;    // 0: expecting high byte, 1: expecting low byte
  logic              href_d;      // href as last seen on a pix_en cycle
  logic [6:0]        hi_q;        // {R5[4:1], G6[5:3]} from the high byte
  logic              in_range;
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       pix;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state: vsync is looked at every cycle, regardless of pix_en
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.cam_vsync)  nxt = SYNC;
      SYNC:    if (!bus.cam_vsync) nxt = ACTIVE;
      ACTIVE:  if (bus.cam_vsync)  nxt = SYNC;
      default: nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.frame_active = (state == ACTIVE);
  end

  // Pixel packing, range test and linear address of the current position
  always_comb begin
    in_range = (col_cnt < COL_MAX) && (line_cnt < LINE_MAX);
`ifdef CAM_DECIMATE_EN
    wr_ok   = in_range && !col_cnt[0] && !line_cnt[0];
    wr_addr = ADDR_W'(line_cnt >> 1) * ADDR_W'(H_PIX) + ADDR_W'(col_cnt >> 1);
`else
    wr_ok   = in_range;
    wr_addr = ADDR_W'(line_cnt) * ADDR_W'(H_PIX) + ADDR_W'(col_cnt);
`endif
    pix = {hi_q, bus.cam_data[7], bus.cam_data[4:1]};
  end

  // Byte assembly, position counters, write port and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt        <= '0;
      line_cnt       <= '0;
      phase_lo       <= 1'b0;
      href_d         <= 1'b0;
      hi_q           <= '0;
      bus.fb_we      <= 1'b0;
      bus.fb_wAddr   <= '0;
      bus.fb_wdata   <= '0;
      bus.frame_done <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.fb_we      <= 1'b0;
      bus.frame_done <= (state == ACTIVE) && bus.cam_vsync;
      if (state == SYNC && !bus.cam_vsync) begin
        // New frame begins on the next cycle
        col_cnt      <= '0;
        line_cnt     <= '0;
        bus.overflow <= 1'b0;
        phase_lo     <= 1'b0;
        href_d       <= 1'b0;
      end else if (state == ACTIVE && bus.cam_vsync) begin
        // Frame end wins over any line end; a dangling high byte is dropped
        phase_lo <= 1'b0;
        href_d   <= 1'b0;
      end else if (state == ACTIVE && bus.pix_en) begin
        href_d <= bus.cam_href;
        if (bus.cam_href) begin
          if (!phase_lo) begin
            hi_q     <= {bus.cam_data[7:4], bus.cam_data[2:0]};
            phase_lo <= 1'b1;
          end else begin
            phase_lo <= 1'b0;
            if (wr_ok) begin
              bus.fb_we    <= 1'b1;
              bus.fb_wAddr <= wr_addr;
              bus.fb_wdata <= pix;
            end
            if (!in_range) bus.overflow <= 1'b1;
            col_cnt <= (col_cnt < COL_MAX) ? col_cnt + 1'b1 : COL_MAX;
          end
        end else if (href_d) begin
          // Line end: empty lines (no complete pixel) do not advance
          phase_lo <= 1'b0;
          if (col_cnt != '0) begin
            col_cnt  <= '0;
            line_cnt <= (line_cnt < LINE_MAX) ? line_cnt + 1'b1 : LINE_MAX;
          end
        end
      end
    end
  end

endmodule
